kmkz_ahb_arbiter: RTL and testbench
===================================

KMKZ_AHB_ARBITER -- requirements
Module: kmkz_ahb_arbiter

Interface
REQ-001 The block SHALL have one parameter: g_d_priority, default 0; 0 = round-robin between I and D, 1 = D always wins.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 nRST  input  1  reset, asynchronous and active-low.
REQ-004 HADDR_I / HADDR_D  input  32  address from the core's instruction / data master.
REQ-005 HTRANS_I / HTRANS_D  input  2  transfer type; bit 1 set = request (NONSEQ or SEQ).
REQ-006 HSIZE_I / HSIZE_D  input  3  transfer size.
REQ-007 HPROT_I / HPROT_D  input  4  protection attributes.
REQ-008 HWRITE_I / HWRITE_D  input  1  write flag.
REQ-009 HWDATA_I / HWDATA_D  input  32  write data, valid in the master's data phase.
REQ-010 HBURST_I / HBURST_D, HMASTLOCK_I / HMASTLOCK_D  input  3 / 1  accepted and ignored.
REQ-011 HRDATA_I / HRDATA_D  output  32  read data returned to the master.
REQ-012 HREADY_I / HREADY_D  output  1  per-master ready.
REQ-013 HRESP_I / HRESP_D  output  1  per-master error response.
REQ-014 HADDR_M, HSIZE_M, HPROT_M, HWRITE_M  output  32/3/4/1  shared-slave address phase.
REQ-015 HTRANS_M  output  2  shared-slave transfer type; only IDLE (00) or NONSEQ (10).
REQ-016 HBURST_M / HMASTLOCK_M  output  3 / 1  tied to SINGLE (000) / 0.
REQ-017 HWDATA_M  output  32  write data of the current data-phase owner.
REQ-018 HRDATA_M, HREADY_M, HRESP_M  input  32/1/1  shared-slave response.

Function
REQ-019 The block SHALL merge the core's two AHB-Lite masters onto one AHB-Lite slave port; every forwarded transfer is SINGLE/NONSEQ.
REQ-020 Per master there SHALL be a pending buffer {valid, addr, size, prot, write}.
- A request is accepted in any cycle where HREADY_x=1 and HTRANS_x[1]=1.
REQ-021 Candidates per master: the pending entry if valid, else a live accepted request.
- Arbitration SHALL occur only in cycles with HREADY_M=1.
REQ-022 Arbitration result:
- One candidate: it wins.
- Two candidates, g_d_priority=1: D wins.
- Two candidates, g_d_priority=0: the master not granted last wins; last_grant updates on every grant.
REQ-023 The winner's fields SHALL drive HADDR_M/HSIZE_M/HPROT_M/HWRITE_M combinationally with HTRANS_M=10.
- No winner: HTRANS_M=00, other address outputs hold last value.
REQ-024 An accepted live request that does not win, or arrives while HREADY_M=0, SHALL be stored in its pending buffer.
- A winning pending entry SHALL be cleared the same edge.
REQ-025 The data-phase owner register dp_owner {NONE, I, D} SHALL be loaded with the winner (or NONE) on each edge where HREADY_M=1, and hold otherwise.
REQ-026 HREADY_x SHALL be:
- 0 while pending_x valid;
- HREADY_M when dp_owner=x;
- otherwise 1.
REQ-027 HRESP_x SHALL be HRESP_M when dp_owner=x, else 0.
- HRDATA_I and HRDATA_D SHALL both carry HRDATA_M.
REQ-028 HWDATA_M SHALL select HWDATA of dp_owner, and 0 when NONE.
- Buffered writes rely on the master holding HWDATA while its HREADY_x=0.
REQ-029 Latency:
- A live request with the bus free reaches HTRANS_M in the same cycle (0 added cycles).
- A losing request is issued at the next HREADY_M=1 edge it wins; I waits at most one D transfer in round-robin mode.
REQ-030 A pending buffer SHALL never overflow, because HREADY_x=0 blocks new requests while it is valid.
REQ-031 On an ERROR response, the error cycles SHALL pass to the owner unchanged.
- The arbiter SHALL not cancel the other master's pending entry.
REQ-032 HTRANS_x = IDLE or BUSY SHALL be ignored, creating no pending entry.

Reset
REQ-033 While nRST=0 the block SHALL force:
- pending valids = 0, dp_owner = NONE, last_grant = D;
- HTRANS_M = 00, HADDR_M = 0, HSIZE_M = 0, HPROT_M = 0, HWRITE_M = 0, HWDATA_M = 0;
- HREADY_I = HREADY_D = 1, HRESP_I = HRESP_D = 0.
REQ-034 Reset asserted mid-transfer SHALL discard all pending and owner state immediately, with no replay after release.

Verification
REQ-035 Scenario: I-only read of 0x100, HREADY_M=1 -> HADDR_M=0x100 and HTRANS_M=10 the same cycle; HRDATA_I=HRDATA_M with HREADY_I=1 the next cycle.
REQ-036 Scenario: I reads 0x200 and D writes 0x300 with 0xDEADBEEF in the same cycle, g_d_priority=0, after reset -> I issued first; D pending with HREADY_D=0; D issued next cycle; HWDATA_M=0xDEADBEEF in D's data phase.
REQ-037 Scenario: same as REQ-036 with g_d_priority=1 -> D issued first, I pending.
REQ-038 Scenario: HREADY_M=0 for 3 cycles during an I read while D requests -> D pending; HTRANS_M holds I's following address or 00; D issued on the first HREADY_M=1 edge.
REQ-039 Scenario: HRESP_M=1 for two cycles on a D transfer -> HRESP_D mirrors it; HRESP_I=0; a pending I completes afterwards.
REQ-040 Scenario: nRST pulsed low while D is pending -> HREADY_D=1 and HTRANS_M=00 immediately; no D transfer appears after release.

Source files
------------

// File: rtl/kmkz_ahb_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter for the core's I and D ports.
// Each forwarded transfer is SINGLE/NONSEQ. A losing request waits in a one-entry pending buffer.
module kmkz_ahb_arbiter #(
  parameter int g_d_priority = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] HADDR_I,
  input  logic [1:0]  HTRANS_I,
  input  logic [2:0]  HSIZE_I,
  input  logic [3:0]  HPROT_I,
  input  logic        HWRITE_I,
  input  logic [31:0] HWDATA_I,
  input  logic [2:0]  HBURST_I,
  input  logic        HMASTLOCK_I,
  output logic [31:0] HRDATA_I,
  output logic        HREADY_I,
  output logic        HRESP_I,
  input  logic [31:0] HADDR_D,
  input  logic [1:0]  HTRANS_D,
  input  logic [2:0]  HSIZE_D,
  input  logic [3:0]  HPROT_D,
  input  logic        HWRITE_D,
  input  logic [31:0] HWDATA_D,
  input  logic [2:0]  HBURST_D,
  input  logic        HMASTLOCK_D,
  output logic [31:0] HRDATA_D,
  output logic        HREADY_D,
  output logic        HRESP_D,
  output logic [31:0] HADDR_M,
  output logic [1:0]  HTRANS_M,
  output logic [2:0]  HSIZE_M,
  output logic [3:0]  HPROT_M,
  output logic        HWRITE_M,
  output logic [2:0]  HBURST_M,
  output logic        HMASTLOCK_M,
  output logic [31:0] HWDATA_M,
  input  logic [31:0] HRDATA_M,
  input  logic        HREADY_M,
  input  logic        HRESP_M
);

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        write;
  } req_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t;

  // Index 0 is the instruction master, index 1 the data master.
  req_t [1:0] live, pend_req, cand_req;
  logic [1:0] pend_vld, trans_req, is_own, hready_x, acc, cand, win;
  own_t       dp_owner;
  logic       last_d;
  req_t       sel, last_q;
  logic       any_win;

  assign live[0]      = {HADDR_I, HSIZE_I, HPROT_I, HWRITE_I};
  assign live[1]      = {HADDR_D, HSIZE_D, HPROT_D, HWRITE_D};
  assign trans_req    = {HTRANS_D[1], HTRANS_I[1]};
  assign is_own       = {dp_owner == OWN_D, dp_owner == OWN_I};

  always_comb begin
    hready_x = '1;
    acc      = '0;
    cand     = '0;
    cand_req = live;
    for (int m = 0; m < 2; m++) begin
      if (pend_vld[m])    hready_x[m] = 1'b0;
      else if (is_own[m]) hready_x[m] = HREADY_M;
      // Live requests are masked during reset so nothing leaks onto the slave bus.
      acc[m]  = hready_x[m] & trans_req[m] & nRST;
      cand[m] = (pend_vld[m] | acc[m]) & HREADY_M;
      if (pend_vld[m]) cand_req[m] = pend_req[m];
    end
  end

  // Round-robin favours whichever master was not granted last.
  always_comb begin
    win = cand;
    if (cand == 2'b11) begin
      if (g_d_priority != 0 || !last_d) win = 2'b10;
      else                              win = 2'b01;
    end
  end

  assign any_win = |win;
  assign sel     = win[1] ? cand_req[1] : cand_req[0];

  assign HTRANS_M                             = any_win ? 2'b10 : 2'b00;
  assign {HADDR_M, HSIZE_M, HPROT_M, HWRITE_M} = any_win ? sel : last_q;
  assign HBURST_M    = 3'b000;
  assign HMASTLOCK_M = 1'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_vld <= '0;
      pend_req <= '0;
      dp_owner <= OWN_NONE;
      last_d   <= 1'b1;
      last_q   <= '0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (win[m]) pend_vld[m] <= 1'b0;
        else if (acc[m]) begin
          pend_vld[m] <= 1'b1;
          pend_req[m] <= live[m];
        end
      end
      if (HREADY_M) dp_owner <= win[1] ? OWN_D : (win[0] ? OWN_I : OWN_NONE);
      if (any_win) begin
        last_d <= win[1];
        last_q <= sel;
      end
    end
  end

  always_comb begin
    case (dp_owner)
      OWN_I:   HWDATA_M = HWDATA_I;
      OWN_D:   HWDATA_M = HWDATA_D;
      default: HWDATA_M = '0;
    endcase
  end

  assign HREADY_I = hready_x[0];
  assign HREADY_D = hready_x[1];
  assign HRESP_I  = is_own[0] & HRESP_M;
  assign HRESP_D  = is_own[1] & HRESP_M;
  assign HRDATA_I = HRDATA_M;
  assign HRDATA_D = HRDATA_M;

  logic unused_ok;
  assign unused_ok = ^{HBURST_I, HBURST_D, HMASTLOCK_I, HMASTLOCK_D, HTRANS_I[0], HTRANS_D[0]};

endmodule

// File: tb/tb_kmkz_ahb_arbiter.sv
// Directed bench for kmkz_ahb_arbiter: a round-robin and a D-priority instance share stimulus;
// slave-side transfers are checked against per-instance expected queues.
module tb_kmkz_ahb_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        write;
  } xfer_t;

  logic CLK = 1'b0;
  logic nRST;
  logic [31:0] HADDR_I, HADDR_D, HWDATA_I, HWDATA_D, HRDATA_M;
  logic [1:0]  HTRANS_I, HTRANS_D;
  logic [2:0]  HSIZE_I, HSIZE_D, HBURST_I, HBURST_D;
  logic [3:0]  HPROT_I, HPROT_D;
  logic        HWRITE_I, HWRITE_D, HMASTLOCK_I, HMASTLOCK_D, HREADY_M, HRESP_M;

  logic [1:0][31:0] hrdata_i, hrdata_d, haddr_m, hwdata_m;
  logic [1:0]       hready_i, hready_d, hresp_i, hresp_d, hwrite_m, hmastlock_m;
  logic [1:0][1:0]  htrans_m;
  logic [1:0][2:0]  hsize_m, hburst_m;
  logic [1:0][3:0]  hprot_m;

  int n_chk = 0, n_pass = 0;
  xfer_t q0[$], q1[$];

  always #5 CLK = ~CLK;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    kmkz_ahb_arbiter #(.g_d_priority(k)) u_dut (
      .CLK(CLK), .nRST(nRST),
      .HADDR_I(HADDR_I), .HTRANS_I(HTRANS_I), .HSIZE_I(HSIZE_I), .HPROT_I(HPROT_I),
      .HWRITE_I(HWRITE_I), .HWDATA_I(HWDATA_I), .HBURST_I(HBURST_I), .HMASTLOCK_I(HMASTLOCK_I),
      .HRDATA_I(hrdata_i[k]), .HREADY_I(hready_i[k]), .HRESP_I(hresp_i[k]),
      .HADDR_D(HADDR_D), .HTRANS_D(HTRANS_D), .HSIZE_D(HSIZE_D), .HPROT_D(HPROT_D),
      .HWRITE_D(HWRITE_D), .HWDATA_D(HWDATA_D), .HBURST_D(HBURST_D), .HMASTLOCK_D(HMASTLOCK_D),
      .HRDATA_D(hrdata_d[k]), .HREADY_D(hready_d[k]), .HRESP_D(hresp_d[k]),
      .HADDR_M(haddr_m[k]), .HTRANS_M(htrans_m[k]), .HSIZE_M(hsize_m[k]), .HPROT_M(hprot_m[k]),
      .HWRITE_M(hwrite_m[k]), .HBURST_M(hburst_m[k]), .HMASTLOCK_M(hmastlock_m[k]),
      .HWDATA_M(hwdata_m[k]), .HRDATA_M(HRDATA_M), .HREADY_M(HREADY_M), .HRESP_M(HRESP_M)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every slave-side address phase must match the next expected transfer.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (htrans_m[k] != 2'b00) begin
        xfer_t got, e;
        bit have;
        check($sformatf("htrans_enc%0d", k), htrans_m[k], 2'b10);
        check($sformatf("burst_lock%0d", k), {hburst_m[k], hmastlock_m[k]}, 4'b0000);
        got  = {haddr_m[k], hsize_m[k], hprot_m[k], hwrite_m[k]};
        have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        check($sformatf("xfer_expected%0d", k), have, 1'b1);
        if (have) begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("xfer%0d", k), got, e);
        end
      end
    end
  end

  function automatic xfer_t xi(input logic [31:0] a);
    return {a, 3'd2, 4'hA, 1'b0};
  endfunction
  function automatic xfer_t xd(input logic [31:0] a, input logic w);
    return {a, 3'd1, 4'h5, w};
  endfunction

  task automatic cyc(); @(posedge CLK); #1; endtask
  task automatic smp(); @(negedge CLK); endtask
  task automatic idle(); HTRANS_I = 2'b00; HTRANS_D = 2'b00; endtask
  task automatic req_i(input logic [31:0] a);
    HTRANS_I = 2'b10; HADDR_I = a; HSIZE_I = 3'd2; HPROT_I = 4'hA; HWRITE_I = 1'b0;
  endtask
  task automatic req_d(input logic [31:0] a, input logic w);
    HTRANS_D = 2'b10; HADDR_D = a; HSIZE_D = 3'd1; HPROT_D = 4'h5; HWRITE_D = w;
  endtask
  task automatic do_reset();
    idle(); HREADY_M = 1'b1; HRESP_M = 1'b0; nRST = 1'b0;
    cyc(); cyc(); nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; HREADY_M = 1'b1; HRESP_M = 1'b0; HRDATA_M = '0;
    HADDR_I = '0; HADDR_D = '0; HSIZE_I = '0; HSIZE_D = '0; HPROT_I = '0; HPROT_D = '0;
    HWRITE_I = 1'b0; HWRITE_D = 1'b0; HWDATA_I = 32'h1234; HWDATA_D = 32'h5678;
    HBURST_I = 3'd1; HBURST_D = 3'd3; HMASTLOCK_I = 1'b1; HMASTLOCK_D = 1'b1;
    idle();
    req_i(32'h55);  // live request during reset must not reach the slave
    smp();
    for (int k = 0; k < 2; k++) begin
      check("rst_htrans", htrans_m[k], 2'b00);
      check("rst_haddr", haddr_m[k], 32'h0);
      check("rst_hwdata", hwdata_m[k], 32'h0);
      check("rst_hready", {hready_i[k], hready_d[k]}, 2'b11);
      check("rst_hresp", {hresp_i[k], hresp_d[k]}, 2'b00);
    end
    cyc(); idle(); nRST = 1'b1;

    // I-only read: zero-latency issue, response next cycle
    cyc(); req_i(32'h100); q0.push_back(xi(32'h100)); q1.push_back(xi(32'h100));
    smp(); check("s1_htrans", htrans_m[0], 2'b10); check("s1_hready_i", hready_i[0], 1'b1);
    cyc(); idle(); HRDATA_M = 32'hA5A50001;
    smp();
    check("s1_hrdata_i", hrdata_i[0], 32'hA5A50001);
    check("s1_hrdata_d", hrdata_d[1], 32'hA5A50001);
    check("s1_hready_i_dp", hready_i[0], 1'b1);
    check("s1_idle", htrans_m[0], 2'b00);
    check("s1_addr_hold", haddr_m[0], 32'h100);

    // Simultaneous I read / D write
    do_reset();
    req_i(32'h200); req_d(32'h300, 1'b1);
    q0.push_back(xi(32'h200)); q0.push_back(xd(32'h300, 1'b1));
    q1.push_back(xd(32'h300, 1'b1)); q1.push_back(xi(32'h200));
    smp(); check("s2_hready_d_rr", hready_d[0], 1'b1); check("s2_hready_i_dp", hready_i[1], 1'b1);
    cyc(); idle(); HWDATA_D = 32'hDEADBEEF; HWDATA_I = 32'h11112222;
    smp();
    check("s2_rr_hready_d_pend", hready_d[0], 1'b0);
    check("s2_rr_hready_i", hready_i[0], 1'b1);
    check("s2_rr_hwdata_i", hwdata_m[0], 32'h11112222);
    check("s2_rr_htrans", htrans_m[0], 2'b10);
    check("s2_dp_hready_i_pend", hready_i[1], 1'b0);
    check("s2_dp_hwdata_d", hwdata_m[1], 32'hDEADBEEF);
    cyc();
    smp();
    check("s2_rr_hwdata_d", hwdata_m[0], 32'hDEADBEEF);
    check("s2_rr_hready_d", hready_d[0], 1'b1);
    check("s2_rr_idle", htrans_m[0], 2'b00);
    check("s2_dp_hwdata_i", hwdata_m[1], 32'h11112222);
    check("s2_dp_hready_i", hready_i[1], 1'b1);

    // Slave wait states during an I read while D requests
    do_reset();
    req_i(32'h400); q0.push_back(xi(32'h400)); q1.push_back(xi(32'h400));
    smp(); check("s3_hready_i", hready_i[0], 1'b1);
    cyc(); HREADY_M = 1'b0; req_i(32'h404); req_d(32'h500, 1'b1);
    smp();
    for (int k = 0; k < 2; k++) begin
      check("s3_wait_htrans", htrans_m[k], 2'b00);
      check("s3_wait_hready_i", hready_i[k], 1'b0);
      check("s3_wait_hready_d", hready_d[k], 1'b1);
    end
    cyc(); HTRANS_D = 2'b00;
    smp();
    for (int k = 0; k < 2; k++) begin
      check("s3_pend_hready_d", hready_d[k], 1'b0);
      check("s3_pend_htrans", htrans_m[k], 2'b00);
    end
    cyc();
    smp(); check("s3_wait3_htrans", htrans_m[0], 2'b00);
    cyc(); HREADY_M = 1'b1;
    q0.push_back(xd(32'h500, 1'b1)); q0.push_back(xi(32'h404));
    q1.push_back(xd(32'h500, 1'b1)); q1.push_back(xi(32'h404));
    smp(); check("s3_rel_hready_i", hready_i[0], 1'b1);
    cyc(); idle();
    smp();
    for (int k = 0; k < 2; k++) begin
      check("s3_i_pend", hready_i[k], 1'b0);
      check("s3_d_dp", hready_d[k], 1'b1);
    end
    cyc();
    smp(); check("s3_done", htrans_m[0], 2'b00);

    // Two-cycle ERROR on a D read, I queued behind it
    do_reset();
    req_d(32'h600, 1'b0); q0.push_back(xd(32'h600, 1'b0)); q1.push_back(xd(32'h600, 1'b0));
    smp();
    cyc(); idle(); req_i(32'h700); HREADY_M = 1'b0; HRESP_M = 1'b1;
    smp();
    for (int k = 0; k < 2; k++) begin
      check("s4_e1_hresp_d", hresp_d[k], 1'b1);
      check("s4_e1_hresp_i", hresp_i[k], 1'b0);
      check("s4_e1_hready_d", hready_d[k], 1'b0);
    end
    cyc(); HTRANS_I = 2'b00; HREADY_M = 1'b1;
    q0.push_back(xi(32'h700)); q1.push_back(xi(32'h700));
    smp();
    for (int k = 0; k < 2; k++) begin
      check("s4_e2_hresp_d", hresp_d[k], 1'b1);
      check("s4_e2_hready_d", hready_d[k], 1'b1);
      check("s4_e2_hresp_i", hresp_i[k], 1'b0);
      check("s4_e2_hready_i", hready_i[k], 1'b0);
    end
    cyc(); HREADY_M = 1'b0; HRESP_M = 1'b1;
    smp();
    check("s4_i_err_hresp_i", hresp_i[0], 1'b1);
    check("s4_i_err_hresp_d", hresp_d[0], 1'b0);
    check("s4_i_err_hready_i", hready_i[0], 1'b0);
    cyc(); HREADY_M = 1'b1;
    smp(); check("s4_i_err2_hready_i", hready_i[0], 1'b1);
    cyc(); HRESP_M = 1'b0;
    smp(); check("s4_clear_hresp_i", hresp_i[0], 1'b0);

    // Reset pulse while a request is pending
    do_reset();
    req_i(32'h800); req_d(32'h900, 1'b1);
    q0.push_back(xi(32'h800)); q1.push_back(xd(32'h900, 1'b1));
    smp();
    cyc(); idle(); nRST = 1'b0; #1;
    check("s5_rr_hready_d", hready_d[0], 1'b1);
    check("s5_dp_hready_i", hready_i[1], 1'b1);
    for (int k = 0; k < 2; k++) begin
      check("s5_htrans", htrans_m[k], 2'b00);
      check("s5_haddr", haddr_m[k], 32'h0);
    end
    cyc(); nRST = 1'b1;
    cyc(); cyc();
    smp();
    for (int k = 0; k < 2; k++) check("s5_no_replay", htrans_m[k], 2'b00);

    // BUSY and IDLE create nothing
    cyc(); HTRANS_I = 2'b01; HADDR_I = 32'hA00; HTRANS_D = 2'b01; HADDR_D = 32'hA04;
    smp(); check("s6_busy_htrans", htrans_m[0], 2'b00);
    cyc(); idle();
    smp(); check("s6_busy_hready", {hready_i[0], hready_d[0]}, 2'b11);

    // Round-robin fairness with I re-requesting immediately
    do_reset();
    req_i(32'hB00); req_d(32'hC00, 1'b0);
    q0.push_back(xi(32'hB00)); q0.push_back(xd(32'hC00, 1'b0)); q0.push_back(xi(32'hB04));
    q1.push_back(xd(32'hC00, 1'b0)); q1.push_back(xi(32'hB00));
    smp();
    cyc(); HTRANS_D = 2'b00; req_i(32'hB04);
    smp(); check("s7_rr_hready_i", hready_i[0], 1'b1);
    cyc(); idle();
    smp(); check("s7_rr_i_pend", hready_i[0], 1'b0);
    cyc(); cyc();
    smp();
    check("s7_q0_drained", q0.size(), 0);
    check("s7_q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
